// File: rtl/mcpu_fetch_unit.sv
// Instruction prefetch stage: sequential fetch into a small queue and hand-off to the decoder.
// A branch redirect flushes the queue. It also drops the result of a fetch that is still in flight.
module mcpu_fetch_unit #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   output logic [WORD_SIZE-1:0]  instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
   logic [WORD_SIZE-1:0]  q_data [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      occ_next;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic                  stale;
   logic                  slot_free;
   logic                  ack;
   logic                  push;
   logic                  pop;
   logic                  issue;

   // Handshake decode and next-request decision
   always_comb begin
      slot_free  = !mem_req || mem_ack;
      ack        = mem_req && mem_ack;
      push       = ack && !stale && !redirect_valid;
      pop        = instr_valid && instr_ready && !redirect_valid;
      occ_next   = count;
      if (redirect_valid)
         occ_next = '0;
      else if (push && !pop)
         occ_next = count + CNT_W'(1);
      else if (pop && !push)
         occ_next = count - CNT_W'(1);
      issue      = slot_free && (occ_next < CNT_W'(DEPTH));
      issue_addr = redirect_valid ? redirect_pc : fetch_pc;
   end

   assign instr_valid = (count != '0);
   assign instr_data  = q_data[rd_ptr];
   assign instr_pc    = q_pc[rd_ptr];

   // Fetch control, occupancy and pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req  <= 1'b0;
         mem_addr <= '0;
         fetch_pc <= '0;
         count    <= '0;
         stale    <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         count <= occ_next;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (slot_free) begin
            mem_req <= issue;
            if (issue) mem_addr <= issue_addr;
         end
         if (slot_free && issue)
            fetch_pc <= issue_addr + ADDR_WIDTH'(1);
         else if (redirect_valid)
            fetch_pc <= redirect_pc;
         // A redirect over an unacked fetch marks its eventual data as garbage
         if (ack)
            stale <= 1'b0;
         else if (redirect_valid && mem_req)
            stale <= 1'b1;
      end
   end

   // Queue storage; cleared on reset so the head reads as zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_pc[i]   <= '0;
            q_data[i] <= '0;
         end
      end else if (push) begin
         q_pc[wr_ptr]   <= mem_addr;
         q_data[wr_ptr] <= mem_rdata;
      end
   end

endmodule
